// File: rtl/react_pkg.sv
// Shared types and constants for the reaction-timer controller.
package react_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DELAY       = 3'd1,
    COUNT       = 3'd2,
    DONE        = 3'd3,
    FALSE_START = 3'd4
  } state_t;

  localparam int          MS_W      = 20;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the 16-bit Galois LFSR; a non-zero seed never reaches 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Key inputs and display-path outputs of the reaction timer.
// best_ms exists only when REACT_BEST_TIME_EN is defined.
interface reaction_timer_ctrl_if;
  import react_pkg::*;

  logic            start_n;
  logic            stop_n;
  logic            led;
  logic [MS_W-1:0] ms_count;
  logic            done;
  logic            early;
  logic [2:0]      state_o;
`ifdef REACT_BEST_TIME_EN
  logic [MS_W-1:0] best_ms;

  modport master (output start_n, stop_n,
                  input  led, ms_count, done, early, state_o, best_ms);
  modport slave  (input  start_n, stop_n,
                  output led, ms_count, done, early, state_o, best_ms);
`else
  modport master (output start_n, stop_n,
                  input  led, ms_count, done, early, state_o);
  modport slave  (input  start_n, stop_n,
                  output led, ms_count, done, early, state_o);
`endif
endinterface

// File: rtl/key_debounce.sv
// Key conditioning: 2-flop synchronizer, stability debouncer and a one-cycle
// press pulse on the debounced 1->0 transition. Keys are active-low and idle high.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the raw key into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Down-count while the synced level disagrees; accept it at terminal count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q == '0) begin
      level_d = sync2_q;
      cnt_d   = CNT_LOAD;
      press_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Debounce state and registered press pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer control: key conditioning, pseudo-random pre-LED delay,
// millisecond counting and result presentation for the BCD display path.
// Optional feature macro: REACT_BEST_TIME_EN (adds best_ms minimum tracking).
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | waiting for the first start press
// DELAY       | random wait before the LED, stop here is a false start
// COUNT       | LED lit, ms_count increments each ms tick
// DONE        | result valid and held, start begins a new round
// FALSE_START | stop pressed during DELAY, start begins a new round
module reaction_timer_ctrl
  import react_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_COUNT    = 999999
) (
  input logic                 clk,
  input logic                 reset_n,
  reaction_timer_ctrl_if.slave bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_W = $clog2(MIN_DELAY_MS + 1025);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]  MS_MAX   = MS_W'(MAX_COUNT);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MAX_COUNT - 1);
  localparam logic [DLY_W-1:0] DLY_MIN  = DLY_W'(MIN_DELAY_MS);

  logic             start_p, stop_p;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [DLY_W-1:0] delay_load;
  logic             enter_delay, enter_count, enter_done, sat_hit;

  state_t           state_q;
  logic             led_q, done_q, early_q;
  logic [MS_W-1:0]  ms_q;
  logic [DLY_W-1:0] delay_cnt_q;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n_i (bus.start_n),
    .press_o (start_p)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_stop_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n_i (bus.stop_n),
    .press_o (stop_p)
  );

  assign lfsr_d     = lfsr_next(lfsr_q);
  assign tick       = (div_q == DIV_LAST);
  assign delay_load = DLY_MIN + DLY_W'(lfsr_q[9:0]);

  // Transition decode shared by the divider, FSM and best-time tracker.
  // Stop outranks start/tick in DELAY and COUNT; start outranks stop elsewhere.
  always_comb begin
    enter_delay = 1'b0;
    enter_count = 1'b0;
    sat_hit     = 1'b0;
    enter_done  = 1'b0;
    case (state_q)
      IDLE, DONE, FALSE_START: enter_delay = start_p;
      DELAY:  enter_count = !stop_p && tick && (delay_cnt_q == DLY_W'(1));
      COUNT: begin
        sat_hit    = !stop_p && tick && (ms_q >= MS_LAST);
        enter_done = stop_p || sat_hit;
      end
      default: ;
    endcase
  end

  // Free-running ms divider, realigned on entry to DELAY and COUNT.
  always_comb begin
    if (enter_delay || enter_count || tick) div_d = '0;
    else                                    div_d = div_q + 1'b1;
  end

  // LFSR advances every cycle; divider holds its phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
      div_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      div_q  <= div_d;
    end
  end

  // Round sequencing with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      led_q       <= 1'b0;
      ms_q        <= '0;
      done_q      <= 1'b0;
      early_q     <= 1'b0;
      delay_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, FALSE_START: begin
          if (enter_delay) begin
            state_q     <= DELAY;
            delay_cnt_q <= delay_load;
            ms_q        <= '0;
            led_q       <= 1'b0;
            done_q      <= 1'b0;
            early_q     <= 1'b0;
          end
        end
        DELAY: begin
          if (stop_p) begin
            state_q <= FALSE_START;
            early_q <= 1'b1;
          end else if (enter_count) begin
            state_q <= COUNT;
            led_q   <= 1'b1;
            ms_q    <= '0;
          end else if (tick) begin
            delay_cnt_q <= delay_cnt_q - 1'b1;
          end
        end
        COUNT: begin
          if (enter_done) begin
            state_q <= DONE;
            led_q   <= 1'b0;
            done_q  <= 1'b1;
            if (sat_hit) ms_q <= MS_MAX;
          end else if (tick) begin
            ms_q <= ms_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef REACT_BEST_TIME_EN
  logic            done_entry_q;
  logic [MS_W-1:0] best_q;

  // Fold the frozen result into the minimum one cycle after entering DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_entry_q <= 1'b0;
      best_q       <= MS_MAX;
    end else begin
      done_entry_q <= enter_done;
      if (done_entry_q && (ms_q < best_q)) best_q <= ms_q;
    end
  end

  assign bus.best_ms = best_q;
`endif

  assign bus.led      = led_q;
  assign bus.ms_count = ms_q;
  assign bus.done     = done_q;
  assign bus.early    = early_q;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed/randomized bench for reaction_timer_ctrl with a timing reference model.
module tb_reaction_timer_ctrl;

  localparam int TD = 10;
  localparam int DC = 4;
  localparam int MD = 5;
  localparam int MX = 50;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  reaction_timer_ctrl_if bus();

  reaction_timer_ctrl #(
    .TICK_DIV(TD), .DEBOUNCE_CYC(DC), .MIN_DELAY_MS(MD), .MAX_COUNT(MX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock edges since reset release; the DUT LFSR advances once per such edge.
  int ecount = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecount <= 0;
    else          ecount <= ecount + 1;
  end

  // Event monitor: edge index at which DELAY / DONE were entered and LED rose.
  int e_delay = 0, e_led = 0, e_done = 0, n_led_rise = 0, n_delay_entry = 0;
  logic [2:0] st_prev  = 3'd0;
  logic       led_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.state_o == 3'd1 && st_prev != 3'd1) begin
      e_delay       <= ecount;
      n_delay_entry <= n_delay_entry + 1;
    end
    if (bus.state_o == 3'd3 && st_prev != 3'd3) e_done <= ecount;
    if (bus.led === 1'b1 && led_prev !== 1'b1) begin
      e_led      <= ecount;
      n_led_rise <= n_led_rise + 1;
    end
    st_prev  <= bus.state_o;
    led_prev <= bus.led;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // LFSR value after n advances from the seed.
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  task automatic press(input bit s, input bit t);
    bus.start_n = ~s;
    bus.stop_n  = ~t;
    repeat (8) step();
    bus.start_n = 1'b1;
    bus.stop_n  = 1'b1;
    repeat (10) step();
  endtask

  task automatic wait_led(input string tag);
    int n;
    n = 0;
    while (bus.led !== 1'b1 && n < 11000) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.led), 32'd1);
  endtask

  // LED must rise exactly (MIN_DELAY + lfsr[9:0]) ms after the DELAY entry,
  // using the LFSR value seen on the entry edge.
  task automatic chk_delay(input string tag);
    logic [15:0] v;
    v = lfsr_after(e_delay - 1);
    chk(tag, e_led - e_delay, TD * (MD + int'(v[9:0])));
  endtask

  // Release stop (optionally with start) so the press lands mid-way between
  // tick `target` and tick target+1, away from any tick boundary.
  task automatic stop_round(input int target, input bit with_start, input string tag);
    int r;
    int w;
    r = $urandom_range(7, 3);
    w = TD * target - 7 + r - (ecount - e_led);
    repeat (w) step();
    press(with_start, 1'b1);
    chk(tag, 32'(bus.ms_count), target);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lr;
    int n;
    int t5;
    int targets[3];
    int exp_best;

    targets = '{30, 20, 25};
    bus.start_n = 1'b1;
    bus.stop_n  = 1'b1;
    reset_n     = 1'b0;
    repeat (3) step();

    chk("rst_led",   32'(bus.led),      32'd0);
    chk("rst_ms",    32'(bus.ms_count), 32'd0);
    chk("rst_done",  32'(bus.done),     32'd0);
    chk("rst_early", 32'(bus.early),    32'd0);
    chk("rst_state", 32'(bus.state_o),  32'd0);
`ifdef REACT_BEST_TIME_EN
    chk("rst_best",  32'(bus.best_ms),  MX);
`endif
    reset_n = 1'b1;
    repeat ($urandom_range(40, 1)) step();

    // Key glitch then a proper hold.
    bus.start_n = 1'b0;
    repeat (3) step();
    bus.start_n = 1'b1;
    repeat (20) step();
    chk("glitch_state", 32'(bus.state_o), 32'd0);
    chk("glitch_no_entry", n_delay_entry, 0);
    bus.start_n = 1'b0;
    repeat (8) step();
    bus.start_n = 1'b1;
    repeat (20) step();
    chk("hold_state", 32'(bus.state_o), 32'd1);
    chk("hold_one_entry", n_delay_entry, 1);

    // Normal round of 37 ms.
    wait_led("r1_led_rise");
    chk_delay("r1_delay");
    chk("r1_ms_at_led", 32'(bus.ms_count), 32'd0);
    stop_round(37, 1'b0, "r1_ms");
    chk("r1_done",  32'(bus.done),    32'd1);
    chk("r1_led",   32'(bus.led),     32'd0);
    chk("r1_state", 32'(bus.state_o), 32'd3);
    repeat (1000) step();
    chk("r1_ms_stable", 32'(bus.ms_count), 32'd37);
    chk("r1_done_stable", 32'(bus.done), 32'd1);
    exp_best = 37;
`ifdef REACT_BEST_TIME_EN
    chk("r1_best", 32'(bus.best_ms), exp_best);
`endif

    // False start.
    press(1'b1, 1'b0);
    chk("fs_in_delay", 32'(bus.state_o), 32'd1);
    chk("fs_done_clr", 32'(bus.done), 32'd0);
    chk("fs_ms_clr", 32'(bus.ms_count), 32'd0);
    lr = n_led_rise;
    press(1'b0, 1'b1);
    chk("fs_state", 32'(bus.state_o), 32'd4);
    chk("fs_early", 32'(bus.early), 32'd1);
    chk("fs_led", 32'(bus.led), 32'd0);
    chk("fs_ms", 32'(bus.ms_count), 32'd0);
    repeat (200) step();
    chk("fs_no_led", n_led_rise, lr);
    chk("fs_held", 32'(bus.state_o), 32'd4);
`ifdef REACT_BEST_TIME_EN
    chk("fs_best", 32'(bus.best_ms), exp_best);
`endif
    press(1'b1, 1'b0);
    chk("fs_restart_state", 32'(bus.state_o), 32'd1);
    chk("fs_restart_early", 32'(bus.early), 32'd0);

    // Saturation at MAX_COUNT with no stop.
    wait_led("sat_led_rise");
    chk_delay("sat_delay");
    n = 0;
    while (bus.state_o !== 3'd3 && n < 700) begin
      step();
      n++;
    end
    chk("sat_state", 32'(bus.state_o), 32'd3);
    chk("sat_ms", 32'(bus.ms_count), MX);
    chk("sat_time", e_done - e_led, TD * MX);
    repeat (200) step();
    chk("sat_no_wrap", 32'(bus.ms_count), MX);
    chk("sat_led_off", 32'(bus.led), 32'd0);

    // Simultaneous presses: stop wins in COUNT, start wins in DONE.
    press(1'b1, 1'b0);
    chk("pri_delay", 32'(bus.state_o), 32'd1);
    wait_led("pri_led_rise");
    chk_delay("pri_delay_len");
    t5 = $urandom_range(45, 35);
    stop_round(t5, 1'b1, "pri_count_ms");
    chk("pri_count_state", 32'(bus.state_o), 32'd3);
    chk("pri_count_done", 32'(bus.done), 32'd1);
    press(1'b1, 1'b1);
    chk("pri_done_state", 32'(bus.state_o), 32'd1);
    chk("pri_done_clr", 32'(bus.done), 32'd0);
    chk("pri_ms_clr", 32'(bus.ms_count), 32'd0);
    chk("pri_early", 32'(bus.early), 32'd0);

    // Reset in the middle of COUNT.
    wait_led("rst_led_rise");
    chk_delay("rst_delay");
    n = 0;
    while (bus.ms_count !== 20'd12 && n < 300) begin
      step();
      n++;
    end
    chk("mid_reach12", 32'(bus.ms_count), 32'd12);
    reset_n = 1'b0;
    #1;
    chk("mid_led",   32'(bus.led),      32'd0);
    chk("mid_ms",    32'(bus.ms_count), 32'd0);
    chk("mid_done",  32'(bus.done),     32'd0);
    chk("mid_early", 32'(bus.early),    32'd0);
    chk("mid_state", 32'(bus.state_o),  32'd0);
`ifdef REACT_BEST_TIME_EN
    chk("mid_best",  32'(bus.best_ms),  MX);
`endif
    repeat (2) step();
    reset_n = 1'b1;
    repeat ($urandom_range(30, 1)) step();

    // Three timed rounds; the minimum is tracked when the feature is built in.
    exp_best = MX;
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0);
      chk("br_delay", 32'(bus.state_o), 32'd1);
      wait_led("br_led_rise");
      chk_delay("br_delay_len");
      stop_round(targets[i], 1'b0, "br_ms");
      if (targets[i] < exp_best) exp_best = targets[i];
      repeat (3) step();
`ifdef REACT_BEST_TIME_EN
      chk("br_best", 32'(bus.best_ms), exp_best);
`endif
    end
`ifdef REACT_BEST_TIME_EN
    chk("best_final", 32'(bus.best_ms), 32'd20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
